// File: rtl/iter_exec_pkg.sv
// Shared types and field positions for the iterative multiply/shift sequencer.
package iter_exec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic OP_MUL   = 1'b0;
  localparam logic OP_SHIFT = 1'b1;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // Shift-control fields inside DATA2.
  localparam int AMT_LSB  = 0;
  localparam int AMT_MSB  = 3;
  localparam int MODE_LSB = 4;
  localparam int MODE_MSB = 5;

endpackage

// File: rtl/iter_exec_datapath.sv
// Working registers for the sequencer: shift-add accumulator, shift register,
// step counter and the result/flag registers seen by the CPU.
module iter_exec_datapath
  import iter_exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               accept,
  input  logic               step_mul,
  input  logic               step_shift,
  input  logic               load_result,
  input  logic               load_direct,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               last_mul,
  output logic               last_shift,
  output logic [WIDTH-1:0]   RESULT,
  output logic [WIDTH-1:0]   PRODUCT_HI,
  output logic               ZERO
);

  localparam int CNT_W = $clog2(WIDTH + 16);

  logic [2*WIDTH-1:0] acc, acc_next, mcand;
  logic [WIDTH-1:0]   mplier, sreg, sreg_next;
  logic [1:0]         mode;
  logic [3:0]         amt;
  logic               fill_msb;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   res_lo_d, res_hi_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_next  = mplier[0] ? acc + mcand : acc;
    sreg_next = sreg;
    unique case (mode)
      SLL: sreg_next = {sreg[WIDTH-2:0], 1'b0};
      SRL: sreg_next = {1'b0, sreg[WIDTH-1:1]};
      SRA: sreg_next = {fill_msb, sreg[WIDTH-1:1]};
      ROR: sreg_next = {sreg[0], sreg[WIDTH-1:1]};
      default: sreg_next = sreg;
    endcase
  end

  assign last_mul   = (count == CNT_W'(WIDTH - 1));
  assign last_shift = (count == CNT_W'(amt) - CNT_W'(1));

  // The final step and the result load share one edge, so results come from the next-values.
  always_comb begin
    res_lo_d = acc_next[WIDTH-1:0];
    res_hi_d = acc_next[2*WIDTH-1:WIDTH];
    if (load_direct) begin
      res_lo_d = DATA1;
      res_hi_d = '0;
    end else if (step_shift) begin
      res_lo_d = sreg_next;
      res_hi_d = '0;
    end
  end

  // NOTE: working registers carry no reset; every operation reinitialises them on accept.
  always_ff @(posedge CLK) begin
    if (accept) begin
      acc      <= '0;
      mcand    <= {{WIDTH{1'b0}}, DATA1};
      mplier   <= DATA2;
      sreg     <= DATA1;
      mode     <= DATA2[MODE_MSB:MODE_LSB];
      amt      <= DATA2[AMT_MSB:AMT_LSB];
      fill_msb <= DATA1[WIDTH-1];
      count    <= '0;
    end else if (step_mul) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end else if (step_shift) begin
      sreg  <= sreg_next;
      count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      RESULT     <= '0;
      PRODUCT_HI <= '0;
      ZERO       <= 1'b0;
    end else if (load_result) begin
      RESULT     <= res_lo_d;
      PRODUCT_HI <= res_hi_d;
      ZERO       <= (res_lo_d == '0);
    end
  end

endmodule

// File: rtl/iter_exec_sequencer.sv
// Iterative multiply/shift sequencer: control FSM plus STALL/BUSY/DONE handshake
// around the shared datapath.
module iter_exec_sequencer
  import iter_exec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             STALL,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic [WIDTH-1:0] PRODUCT_HI,
  output logic             ZERO
);

  state_t state, state_next;
  logic   accept, step_mul, step_shift, load_result, load_direct;
  logic   last_mul, last_shift;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    step_mul    = 1'b0;
    step_shift  = 1'b0;
    load_result = 1'b0;
    load_direct = 1'b0;
    unique case (state)
      IDLE: if (START) begin
        accept = 1'b1;
        if (OP == OP_MUL) begin
          state_next = MUL;
        end else if (DATA2[AMT_MSB:AMT_LSB] != 4'd0) begin
          state_next = SHIFT;
        end else begin
          state_next  = FINISH;
          load_result = 1'b1;
          load_direct = 1'b1;
        end
      end
      MUL: begin
        step_mul = 1'b1;
        if (last_mul) begin
          load_result = 1'b1;
          state_next  = FINISH;
        end
      end
      SHIFT: begin
        step_shift = 1'b1;
        if (last_shift) begin
          load_result = 1'b1;
          state_next  = FINISH;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign BUSY  = (state == MUL) || (state == SHIFT);
  assign DONE  = (state == FINISH);
  assign STALL = ((state == IDLE) && START) || BUSY;

  iter_exec_datapath #(.WIDTH(WIDTH)) u_datapath (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .accept      (accept),
    .step_mul    (step_mul),
    .step_shift  (step_shift),
    .load_result (load_result),
    .load_direct (load_direct),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .last_mul    (last_mul),
    .last_shift  (last_shift),
    .RESULT      (RESULT),
    .PRODUCT_HI  (PRODUCT_HI),
    .ZERO        (ZERO)
  );

endmodule

// File: tb/tb_iter_exec_sequencer.sv
// Directed bench for iter_exec_sequencer: latency, results, flags, ignored START and reset abort.
module tb_iter_exec_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic       OP = 1'b0;
  logic [7:0] DATA1 = '0;
  logic [7:0] DATA2 = '0;
  logic       BUSY, STALL, DONE, ZERO;
  logic [7:0] RESULT, PRODUCT_HI;

  int n_checks = 0;
  int n_pass   = 0;

  iter_exec_sequencer #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .OP         (OP),
    .DATA1      (DATA1),
    .DATA2      (DATA2),
    .BUSY       (BUSY),
    .STALL      (STALL),
    .DONE       (DONE),
    .RESULT     (RESULT),
    .PRODUCT_HI (PRODUCT_HI),
    .ZERO       (ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Accept cycle is cycle 0; exp_done_cyc is the index of the cycle in which DONE is high.
  task automatic run_op(input string tag, input logic op, input logic [7:0] d1, input logic [7:0] d2,
                        input int exp_done_cyc, input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                        input logic exp_zero);
    int   cyc;
    logic stall_ok;
    @(negedge CLK);
    START = 1'b1; OP = op; DATA1 = d1; DATA2 = d2;
    #1 check({tag, ".stall_accept"}, STALL, 1);
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
    stall_ok = 1'b1;
    while (!DONE && cyc < 40) begin
      if (!STALL || !BUSY) stall_ok = 1'b0;
      @(negedge CLK);
      cyc++;
    end
    check({tag, ".done_cycle"}, cyc, exp_done_cyc);
    check({tag, ".stall_busy"}, stall_ok, 1);
    check({tag, ".stall_finish"}, STALL, 0);
    check({tag, ".result"}, RESULT, exp_lo);
    check({tag, ".product_hi"}, PRODUCT_HI, exp_hi);
    check({tag, ".zero"}, ZERO, exp_zero);
    @(negedge CLK);
    check({tag, ".done_pulse"}, DONE, 0);
    check({tag, ".result_hold"}, RESULT, exp_lo);
  endtask

  initial begin
    int dones;
    // Reset with START held high: the request must not be accepted.
    START = 1'b1; OP = 1'b0; DATA1 = 8'h11; DATA2 = 8'h11;
    repeat (3) @(negedge CLK);
    check("reset.busy", BUSY, 0);
    check("reset.done", DONE, 0);
    check("reset.result", RESULT, 0);
    check("reset.product_hi", PRODUCT_HI, 0);
    check("reset.zero", ZERO, 0);
    START = 1'b0;
    RESET_N = 1'b1;
    @(negedge CLK);
    check("reset.no_accept", BUSY, 0);

    run_op("mul_07x06", 1'b0, 8'h07, 8'h06, 9, 8'h2A, 8'h00, 1'b0);
    run_op("mul_ffxff", 1'b0, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 1'b0);
    run_op("mul_10x10", 1'b0, 8'h10, 8'h10, 9, 8'h00, 8'h01, 1'b1);
    run_op("ror2",      1'b1, 8'h81, 8'h32, 3, 8'h60, 8'h00, 1'b0);
    run_op("sra3",      1'b1, 8'h80, 8'h23, 4, 8'hF0, 8'h00, 1'b0);
    run_op("srl4",      1'b1, 8'hF0, 8'h14, 5, 8'h0F, 8'h00, 1'b0);
    run_op("sll10",     1'b1, 8'h01, 8'h0A, 11, 8'h00, 8'h00, 1'b1);
    run_op("mul_ffx01", 1'b0, 8'hFF, 8'h01, 9, 8'hFF, 8'h00, 1'b0);
    run_op("shift0",    1'b1, 8'h5A, 8'h10, 1, 8'h5A, 8'h00, 1'b0);

    // START during MUL cycle 3 must be ignored and leave the latched operands alone.
    @(negedge CLK);
    START = 1'b1; OP = 1'b0; DATA1 = 8'h03; DATA2 = 8'h05;
    @(negedge CLK);
    START = 1'b0;
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        START = 1'b1; DATA1 = 8'h09; DATA2 = 8'h09;
      end else begin
        START = 1'b0;
      end
      if (DONE) begin
        dones++;
        check("ignore.done_cycle", c, 9);
        check("ignore.result", RESULT, 8'h0F);
      end
      @(negedge CLK);
    end
    check("ignore.done_count", dones, 1);

    // Reset during MUL cycle 4 aborts the operation without a DONE pulse.
    START = 1'b1; OP = 1'b0; DATA1 = 8'h0F; DATA2 = 8'h0F;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort.busy_before", BUSY, 1);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("abort.busy", BUSY, 0);
    check("abort.done", DONE, 0);
    check("abort.stall", STALL, 0);
    check("abort.result", RESULT, 0);
    RESET_N = 1'b1;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (DONE) dones++;
      @(negedge CLK);
    end
    check("abort.no_done", dones, 0);
    run_op("mul_02x04", 1'b0, 8'h02, 8'h04, 9, 8'h08, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
